// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel filter.
// Optional threshold output mode is compiled in with SOBEL_THRESH_EN.
package sobel_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned GRAD_W    = DEF_WIDTH + 3;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_GX  = 2'd1,
    MODE_GY  = 2'd2,
    MODE_THR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [31:0] saturate(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line store with one synchronous read and one write per cycle.
// Both rows share the same read and write address.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic [WIDTH-1:0] wdata1_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o
);

  logic [WIDTH-1:0] mem0_q [DEPTH];
  logic [WIDTH-1:0] mem1_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem0_q[waddr_i] <= wdata0_i;
      mem1_q[waddr_i] <= wdata1_i;
    end
    rdata0_o <= mem0_q[raddr_i];
    rdata1_o <= mem1_q[raddr_i];
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter, raster-order input, interior-only output.
// Threshold mode (3) is built only when SOBEL_THRESH_EN is defined.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned MAX_WIDTH  = 1024,
  parameter  int unsigned MAX_HEIGHT = 1024,
  localparam int unsigned CW         = $clog2(MAX_WIDTH + 1),
  localparam int unsigned RW         = $clog2(MAX_HEIGHT + 1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    img_width,
  input  logic [RW-1:0]    img_height,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] thresh,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pixel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pixel,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned GW = WIDTH + (GRAD_W - DEF_WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    w_q, w_d, col_q, col_d;
  logic [RW-1:0]    h_q, h_d, row_q, row_d;
  mode_e            mode_q, mode_d;
  logic             ov_q, ov_d, last_q, last_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] pix_q, pix_d;
  logic [WIDTH-1:0] win_q [3][3];
  logic [WIDTH-1:0] nw [3][3];
  logic [WIDTH-1:0] lb0, lb1, res;
  logic             accept, legal, col_end, row_end, produce;
  logic [GW-1:0]    gx_p, gx_n, gy_p, gy_n, gx, gy, ax, ay;
  logic [GW:0]      mag;

`ifdef SOBEL_THRESH_EN
  logic [WIDTH-1:0] thr_q, thr_d;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  assign in_ready  = (state_q == ST_RUN) && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign col_end   = (col_q == w_q - CW'(1));
  assign row_end   = (row_q == h_q - RW'(1));
  assign produce   = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign legal     = (img_width  >= CW'(3)) && (img_width  <= CW'(MAX_WIDTH)) &&
                     (img_height >= RW'(3)) && (img_height <= RW'(MAX_HEIGHT));

  // Read address follows the next column so the row data is ready on the accepting cycle.
  sobel_line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_WIDTH),
    .AW    (AW)
  ) u_lb (
    .clk      (clk),
    .we_i     (accept),
    .waddr_i  (AW'(col_q)),
    .wdata0_i (in_pixel),
    .wdata1_i (lb0),
    .raddr_i  (AW'(col_d)),
    .rdata0_o (lb0),
    .rdata1_o (lb1)
  );

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        nw[r][c] = win_q[r][c+1];
      end
    end
    nw[0][2] = lb1;
    nw[1][2] = lb0;
    nw[2][2] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= nw[r][c];
        end
      end
    end
  end

  always_comb begin
    gx_p = GW'(nw[0][2]) + (GW'(nw[1][2]) << 1) + GW'(nw[2][2]);
    gx_n = GW'(nw[0][0]) + (GW'(nw[1][0]) << 1) + GW'(nw[2][0]);
    gy_p = GW'(nw[2][0]) + (GW'(nw[2][1]) << 1) + GW'(nw[2][2]);
    gy_n = GW'(nw[0][0]) + (GW'(nw[0][1]) << 1) + GW'(nw[0][2]);
    gx   = gx_p - gx_n;
    gy   = gy_p - gy_n;
    ax   = gx[GW-1] ? ('0 - gx) : gx;
    ay   = gy[GW-1] ? ('0 - gy) : gy;
    mag  = {1'b0, ax} + {1'b0, ay};
    case (mode_q)
      MODE_GX: res = WIDTH'(saturate(32'(ax), WIDTH));
      MODE_GY: res = WIDTH'(saturate(32'(ay), WIDTH));
`ifdef SOBEL_THRESH_EN
      MODE_THR: res = (mag >= (GW+1)'(thr_q)) ? '1 : '0;
`endif
      default: res = WIDTH'(saturate(32'(mag), WIDTH));
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    mode_d  = mode_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SOBEL_THRESH_EN
    thr_d   = thr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (legal) begin
            w_d     = img_width;
            h_d     = img_height;
            mode_d  = mode_e'(mode);
`ifdef SOBEL_THRESH_EN
            thr_d   = thresh;
`endif
            col_d   = '0;
            row_d   = '0;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (col_end && row_end) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!ov_q || out_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ov_d   = ov_q;
    pix_d  = pix_q;
    last_d = last_q;
    if (accept && produce) begin
      ov_d   = 1'b1;
      pix_d  = res;
      last_d = col_end && row_end;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= MODE_SUM;
      col_q   <= '0;
      row_q   <= '0;
      ov_q    <= 1'b0;
      pix_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SOBEL_THRESH_EN
      thr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ov_q    <= ov_d;
      pix_q   <= pix_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SOBEL_THRESH_EN
      thr_q   <= thr_d;
`endif
    end
  end

  assign out_valid = ov_q;
  assign out_pixel = pix_q;
  assign out_last  = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Randomized bench for sobel_stream against a plain-arithmetic Sobel model.
// Threshold expectations follow SOBEL_THRESH_EN when it is defined.
module tb_sobel_stream;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAXW  = 64;
  localparam int unsigned MAXH  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] img_width = '0;
  logic [6:0] img_height = '0;
  logic [1:0] mode = '0;
  logic [7:0] thresh = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       busy, done, cfg_err;

  always #5 clk = ~clk;

  sobel_stream #(
    .WIDTH      (WIDTH),
    .MAX_WIDTH  (MAXW),
    .MAX_HEIGHT (MAXH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .mode       (mode),
    .thresh     (thresh),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int img [0:4095];
  int exp_pix [$];

  task automatic check_eq(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // kind: 0 random, 1 constant v, 2 right column v else 0, 3 ramp
  task automatic fill_img(input int w, input int h, input int kind, input int v);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case (kind)
          0: img[r*w+c] = int'($urandom_range(0, 255));
          1: img[r*w+c] = v;
          2: img[r*w+c] = (c == w-1) ? v : 0;
          default: img[r*w+c] = ((r*w + c) * 4) % 256;
        endcase
      end
    end
  endtask

  task automatic build_expected(input int w, input int h, input int m, input int thr);
    int gx, gy, ax, ay, v, mm;
    exp_pix.delete();
    mm = m;
`ifndef SOBEL_THRESH_EN
    if (mm == 3) mm = 0;
`endif
    for (int r = 1; r <= h-2; r++) begin
      for (int c = 1; c <= w-2; c++) begin
        gx = (img[(r-1)*w+c+1] + 2*img[r*w+c+1] + img[(r+1)*w+c+1])
           - (img[(r-1)*w+c-1] + 2*img[r*w+c-1] + img[(r+1)*w+c-1]);
        gy = (img[(r+1)*w+c-1] + 2*img[(r+1)*w+c] + img[(r+1)*w+c+1])
           - (img[(r-1)*w+c-1] + 2*img[(r-1)*w+c] + img[(r-1)*w+c+1]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mm)
          1: v = ax;
          2: v = ay;
          3: v = (ax + ay >= thr) ? 255 : 0;
          default: v = ax + ay;
        endcase
        if (v > 255) v = 255;
        exp_pix.push_back(v);
      end
    end
  endtask

  task automatic run_frame(input int w, input int h, input int m, input int thr,
                           input bit bp, input bit gaps, input int abort_at,
                           input bit poke_start);
    int k = 0, n = 0, cyc = 0, total, limit;
    bit fin = 1'b0;
    build_expected(w, h, m, thr);
    total = exp_pix.size();
    @(negedge clk);
    start = 1'b1; img_width = 7'(w); img_height = 7'(h); mode = 2'(m); thresh = 8'(thr);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; img_width = 7'($urandom); mode = 2'($urandom); thresh = 8'($urandom);
    #1;
    check_eq("start_in_ready", in_ready, 1);
    limit = 30*w*h + 100;
    while (!fin && cyc < limit) begin
      if (done) begin
        check_eq("done_after_last_handshake", n, total);
        check_eq("busy_at_done", busy, 0);
        fin = 1'b1;
        break;
      end
      if (abort_at > 0 && k >= abort_at) break;
      check_eq("busy_in_frame", busy, 1);
      start = poke_start && (k == (w*h)/2);
      if (poke_start) begin img_width = 7'd3; img_height = 7'd3; mode = 2'd1; end
      out_ready = bp ? (cyc % 4 == 0) : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_valid  = (k < w*h) && (!gaps || $urandom_range(0, 3) != 0);
      in_pixel  = (k < w*h) ? 8'(img[k]) : 8'd0;
      #1;
      check_eq("cfg_err_quiet", cfg_err, 0);
      if (bp && out_valid && !out_ready) check_eq("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (n < total) begin
          check_eq("out_pixel", out_pixel, exp_pix[n]);
          check_eq("out_last", out_last, (n == total-1) ? 1 : 0);
        end else begin
          check_eq("extra_output", n + 1, total);
        end
        n++;
      end
      if (in_valid && in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_at > 0) return;
    check_eq("frame_timeout", fin, 1);
    check_eq("result_count", n, total);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("done_single_pulse", done, 0);
      check_eq("idle_after_done", busy, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_pixel"}, out_pixel, 0);
    check_eq({tag, "_out_last"},  out_last,  0);
    check_eq({tag, "_in_ready"},  in_ready,  0);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_done"},      done,      0);
    check_eq({tag, "_cfg_err"},   cfg_err,   0);
  endtask

  task automatic illegal_start(input int w, input int h);
    @(negedge clk);
    start = 1'b1; img_width = 7'(w); img_height = 7'(h);
    @(negedge clk);
    start = 1'b0;
    check_eq("illegal_cfg_err", cfg_err, 1);
    check_eq("illegal_busy", busy, 0);
    check_eq("illegal_in_ready", in_ready, 0);
    @(negedge clk);
    check_eq("illegal_cfg_err_pulse", cfg_err, 0);
    check_eq("illegal_busy_after", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    fill_img(3, 3, 2, 255);
    run_frame(3, 3, 0, 0, 0, 0, 0, 0);
    run_frame(3, 3, 2, 0, 0, 0, 0, 0);

    fill_img(3, 3, 2, 10);
    run_frame(3, 3, 3, 40, 0, 0, 0, 0);
    run_frame(3, 3, 3, 41, 0, 0, 0, 0);

    fill_img(8, 6, 1, 77);
    run_frame(8, 6, 0, 0, 0, 1, 0, 0);

    fill_img(16, 4, 3, 0);
    run_frame(16, 4, 0, 0, 0, 0, 0, 0);
    run_frame(16, 4, 0, 0, 1, 0, 0, 0);
    fill_img(16, 4, 0, 0);
    run_frame(16, 4, 1, 0, 1, 0, 0, 0);

    illegal_start(2, 5);
    illegal_start(5, 2);
    illegal_start(65, 5);
    illegal_start(5, 0);

    fill_img(6, 5, 0, 0);
    run_frame(6, 5, 0, 0, 0, 0, 0, 1);

    fill_img(64, 3, 0, 0);
    run_frame(64, 3, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      int w, h;
      w = int'($urandom_range(3, 12));
      h = int'($urandom_range(3, 8));
      fill_img(w, h, 0, 0);
      run_frame(w, h, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 0, 1, 0, 0);
    end

    fill_img(10, 10, 0, 0);
    run_frame(10, 10, 0, 0, 0, 0, 50, 0);
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    check_reset_outputs("midframe_reset_held");
    rst = 1'b0;
    @(negedge clk);
    fill_img(4, 4, 0, 0);
    run_frame(4, 4, 0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
